// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU. Single-cycle add/sub/logic and illegal
// codes; shifts iterate one bit per cycle. Valid/ready on both sides.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;

    localparam logic [SHW-1:0]  CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]  CNT_ZERO = {SHW{1'b0}};
    localparam logic [XLEN-1:0] XZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] XONE     = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t          state_r, state_next_s;
    logic [XLEN-1:0] acc_r, acc_next_s;
    logic [SHW-1:0]  cnt_r, cnt_next_s;
    logic            sll_r, sll_next_s;
    logic [XLEN-1:0] result_r, result_next_s;
    logic            zero_r, zero_next_s;
    logic            illegal_r, illegal_next_s;
    logic            in_ready_r, out_valid_r;
    logic [XLEN-1:0] acc_shift_s;
    logic [XLEN-1:0] eval_s;
    logic [SHW-1:0]  amt_s;

    // True for the opcodes this unit implements.
    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SLL, OP_SRL: is_legal = 1'b1;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    // Single-cycle result for non-shift ops; illegal codes give zero.
    function automatic logic [XLEN-1:0] alu_eval(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  alu_eval = a + b;
            OP_SUB:  alu_eval = a + ~b + XONE;
            OP_AND:  alu_eval = a & b;
            OP_OR:   alu_eval = a | b;
            OP_XOR:  alu_eval = a ^ b;
            default: alu_eval = XZERO;
        endcase
    endfunction

    assign eval_s      = alu_eval(alu_op, op_a, op_b);
    assign amt_s       = op_b[SHW-1:0];
    assign acc_shift_s = sll_r ? (acc_r << 1'b1) : (acc_r >> 1'b1);

    // Next-state and datapath decode for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_next_s   = state_r;
        acc_next_s     = acc_r;
        cnt_next_s     = cnt_r;
        sll_next_s     = sll_r;
        result_next_s  = result_r;
        zero_next_s    = zero_r;
        illegal_next_s = illegal_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    if ((alu_op == OP_SLL) || (alu_op == OP_SRL)) begin
                        if (amt_s == CNT_ZERO) begin
                            result_next_s  = op_a;
                            zero_next_s    = (op_a == XZERO);
                            illegal_next_s = 1'b0;
                            state_next_s   = ST_DONE;
                        end else begin
                            acc_next_s   = op_a;
                            cnt_next_s   = amt_s;
                            sll_next_s   = (alu_op == OP_SLL);
                            state_next_s = ST_SHIFT;
                        end
                    end else begin
                        result_next_s  = eval_s;
                        zero_next_s    = (eval_s == XZERO);
                        illegal_next_s = ~is_legal(alu_op);
                        state_next_s   = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_next_s = acc_shift_s;
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_next_s  = acc_shift_s;
                    zero_next_s    = (acc_shift_s == XZERO);
                    illegal_next_s = 1'b0;
                    state_next_s   = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= XZERO;
            cnt_r       <= CNT_ZERO;
            sll_r       <= 1'b0;
            result_r    <= XZERO;
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acc_r       <= acc_next_s;
            cnt_r       <= cnt_next_s;
            sll_r       <= sll_next_s;
            result_r    <= result_next_s;
            zero_r      <= zero_next_s;
            illegal_r   <= illegal_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

endmodule
